// File: rtl/blowfish128_stream_ctrl.sv
// Word-serial front/back end for a 128-bit Blowfish core.
// Ports: key word writes, 32-bit in/out valid/ready streams, core drive/return, sticky timeout flag.
module blowfish128_stream_ctrl #(
  parameter int TIMEOUT   = 4096,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         key_wr,
  input  logic [3:0]   key_idx,
  input  logic [31:0]  key_data,
  input  logic [3:0]   key_len_in,
  output logic         key_busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_encrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         err_timeout,
  output logic         core_enable,
  output logic         core_encrypt,
  output logic [127:0] core_pt,
  output logic [511:0] core_key,
  output logic [3:0]   core_key_len,
  input  logic [127:0] core_ct,
  input  logic         core_ready
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

  logic [1:0]     state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   ct_q, ct_d;
  logic [511:0]   key_q, key_d;
  logic [3:0]     klen_q, klen_d;
  logic           enc_q, enc_d;
  logic           err_q, err_d;
  logic           en_q, en_d;
  logic           busy_q, busy_d;
  logic           irdy_q, irdy_d;
  logic           ovld_q, ovld_d;

  logic           in_hs;
  logic           out_hs;
  logic [1:0]     slot;

  assign in_hs  = irdy_q & in_valid;
  assign out_hs = ovld_q & out_ready;
  // Stream word n maps to 32-bit lane 3-n when the MSW goes first.
  assign slot   = MSW_FIRST ? ~cnt_q : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    key_d   = key_q;
    klen_d  = klen_q;
    enc_d   = enc_q;
    err_d   = err_q;

    if (key_wr && state_q != S_RUN) begin
      key_d[{key_idx, 5'd0} +: 32] = key_data;
      klen_d = key_len_in;
    end

    unique case (1'b1)
      (state_q == S_LOAD): begin
        wd_d = '0;
        if (in_hs) begin
          pt_d[{slot, 5'd0} +: 32] = in_data;
          if (cnt_q == 2'd0) enc_d = in_encrypt;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_RUN;
        end
      end
      (state_q == S_RUN): begin
        if (core_ready) begin
          ct_d    = core_ct;
          wd_d    = '0;
          state_d = S_DRAIN;
        end else if (wd_q == WD_MAX) begin
          err_d   = 1'b1;
          wd_d    = '0;
          state_d = S_LOAD;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      (state_q == S_DRAIN): begin
        if (out_hs) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_LOAD;
        end
      end
      default: begin
        cnt_d   = '0;
        wd_d    = '0;
        state_d = S_LOAD;
      end
    endcase

    // Handshake outputs are registered copies of the next state.
    en_d   = (state_d == S_RUN);
    busy_d = (state_d == S_RUN);
    irdy_d = (state_d == S_LOAD);
    ovld_d = (state_d == S_DRAIN);
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      wd_q    <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      key_q   <= '0;
      klen_q  <= '0;
      enc_q   <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      irdy_q  <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      key_q   <= key_d;
      klen_q  <= klen_d;
      enc_q   <= enc_d;
      err_q   <= err_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      irdy_q  <= irdy_d;
      ovld_q  <= ovld_d;
    end
  end

  assign key_busy     = busy_q;
  assign in_ready     = irdy_q;
  assign out_valid    = ovld_q;
  assign out_data     = ovld_q ? ct_q[{slot, 5'd0} +: 32] : 32'd0;
  assign out_last     = ovld_q & (cnt_q == 2'd3);
  assign err_timeout  = err_q;
  assign core_enable  = en_q;
  assign core_encrypt = enc_q;
  assign core_pt      = pt_q;
  assign core_key     = key_q;
  assign core_key_len = klen_q;

endmodule

// File: tb/tb_blowfish128_stream_ctrl.sv
// Directed bench for blowfish128_stream_ctrl with stub cores.
// dut uses the default watchdog; dut_to uses TIMEOUT=16 for the hang case.
module tb_blowfish128_stream_ctrl;

  logic         Clk = 1'b0;
  logic         RstN = 1'b0;
  logic         key_wr = 1'b0;
  logic [3:0]   key_idx = '0;
  logic [31:0]  key_data = '0;
  logic [3:0]   key_len_in = '0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_encrypt = 1'b0;
  logic         out_ready = 1'b0;

  logic         key_busy, in_ready, out_valid, out_last, err_timeout;
  logic         core_enable, core_encrypt;
  logic [31:0]  out_data;
  logic [127:0] core_pt, core_ct;
  logic [511:0] core_key;
  logic [3:0]   core_key_len;
  logic         core_ready = 1'b0;

  logic         key_busy_2, in_ready_2, out_valid_2, out_last_2, err_timeout_2;
  logic         core_enable_2, core_encrypt_2;
  logic [31:0]  out_data_2;
  logic [127:0] core_pt_2, core_ct_2;
  logic [511:0] core_key_2;
  logic [3:0]   core_key_len_2;
  logic         core_ready_2 = 1'b0;

  logic         hang2 = 1'b0;
  logic         mon2 = 1'b0;
  logic         seen_ov2 = 1'b0;
  int           c1 = 0;
  int           c2 = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 Clk = ~Clk;

  blowfish128_stream_ctrl dut (
    .Clk(Clk), .RstN(RstN),
    .key_wr(key_wr), .key_idx(key_idx), .key_data(key_data),
    .key_len_in(key_len_in), .key_busy(key_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_encrypt(in_encrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err_timeout(err_timeout),
    .core_enable(core_enable), .core_encrypt(core_encrypt),
    .core_pt(core_pt), .core_key(core_key), .core_key_len(core_key_len),
    .core_ct(core_ct), .core_ready(core_ready)
  );

  blowfish128_stream_ctrl #(.TIMEOUT(16), .MSW_FIRST(1'b1)) dut_to (
    .Clk(Clk), .RstN(RstN),
    .key_wr(key_wr), .key_idx(key_idx), .key_data(key_data),
    .key_len_in(key_len_in), .key_busy(key_busy_2),
    .in_valid(in_valid), .in_ready(in_ready_2), .in_data(in_data),
    .in_encrypt(in_encrypt),
    .out_valid(out_valid_2), .out_ready(out_ready), .out_data(out_data_2),
    .out_last(out_last_2), .err_timeout(err_timeout_2),
    .core_enable(core_enable_2), .core_encrypt(core_encrypt_2),
    .core_pt(core_pt_2), .core_key(core_key_2), .core_key_len(core_key_len_2),
    .core_ct(core_ct_2), .core_ready(core_ready_2)
  );

  // Stub cores: cipher = plaintext ^ 1, one-cycle ready pulse.
  assign core_ct   = core_pt ^ 128'd1;
  assign core_ct_2 = core_pt_2 ^ 128'd1;

  always @(posedge Clk) begin
    if (!core_enable) begin
      c1 <= 0;
      core_ready <= 1'b0;
    end else begin
      c1 <= c1 + 1;
      core_ready <= (c1 == 19);
    end
  end

  always @(posedge Clk) begin
    if (!core_enable_2) begin
      c2 <= 0;
      core_ready_2 <= 1'b0;
    end else begin
      c2 <= c2 + 1;
      core_ready_2 <= (c2 == 4) && !hang2;
    end
  end

  always @(posedge Clk) begin
    if (!mon2) seen_ov2 <= 1'b0;
    else if (out_valid_2) seen_ov2 <= 1'b1;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] blk, input logic enc,
                            output logic en_pre);
    int g;
    en_pre = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid   = 1'b1;
      in_data    = blk[127 - 32*i -: 32];
      in_encrypt = enc;
      g = 0;
      while (!in_ready && g < 100) begin
        tick;
        g++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL send_ready word %0d: in_ready=%b want 1", i, in_ready);
      end
      if (i == 3) en_pre = core_enable;
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_out: out_valid=%b want 1 after %0d cycles", out_valid, n);
    end
  endtask

  task automatic drain(input logic [127:0] ct);
    logic [31:0] w;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = ct[127 - 32*i -: 32];
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== w || out_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL drain word %0d: v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, out_valid, out_data, out_last, w, (i == 3));
      end
      tick;
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    tick;
    tick;
    n_checks++;
    if (in_ready !== 1'b0 || core_enable !== 1'b0 || out_valid !== 1'b0 ||
        key_busy !== 1'b0 || err_timeout !== 1'b0 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b en=%b ov=%b busy=%b err=%b d=%h want all 0",
               in_ready, core_enable, out_valid, key_busy, err_timeout, out_data);
    end
    RstN = 1'b1;
    tick;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_keys;
    for (int i = 0; i < 16; i++) begin
      key_wr     = 1'b1;
      key_idx    = 4'(i);
      key_data   = 32'(i);
      key_len_in = 4'd4;
      tick;
    end
    key_wr = 1'b0;
    n_checks++;
    if (core_key[63:0] !== 64'h00000001_00000000) begin
      n_fail++;
      $display("FAIL key_low: core_key[63:0]=%h want 0000000100000000", core_key[63:0]);
    end
    n_checks++;
    if (core_key[511:480] !== 32'h0000000F || core_key_len !== 4'd4) begin
      n_fail++;
      $display("FAIL key_high: key15=%h len=%0d want 0000000f 4",
               core_key[511:480], core_key_len);
    end
  endtask

  task automatic test_block;
    logic [127:0] pt;
    logic en_pre;
    int n;
    pt = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    send_block(pt, 1'b1, en_pre);
    n_checks++;
    if (en_pre !== 1'b0 || core_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_rise: before=%b after=%b want 0/1", en_pre, core_enable);
    end
    n_checks++;
    if (core_pt !== pt || core_encrypt !== 1'b1 || key_busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL block_pt: pt=%h enc=%b busy=%b rdy=%b want %h 1 1 0",
               core_pt, core_encrypt, key_busy, in_ready, pt);
    end
    wait_out(n);
    n_checks++;
    if (n !== 21 || core_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL block_latency: cycles=%0d en=%b want 21 0", n, core_enable);
    end
    drain(pt ^ 128'd1);
  endtask

  task automatic test_stall;
    logic [127:0] ct;
    logic [31:0] w;
    logic en_pre;
    logic r;
    int n;
    int got;
    int g;
    ct = 128'h01234567_89ABCDEF_FEDCBA98_76543210 ^ 128'd1;
    send_block(128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b0, en_pre);
    n_checks++;
    if (core_encrypt !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_mode: core_encrypt=%b want 0", core_encrypt);
    end
    wait_out(n);
    got = 0;
    g = 0;
    while (got < 4 && g < 200) begin
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      w = ct[127 - 32*got -: 32];
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== w || out_last !== (got == 3)) begin
        n_fail++;
        $display("FAIL stall_word %0d: v=%b d=%h l=%b want v=1 d=%h l=%b",
                 got, out_valid, out_data, out_last, w, (got == 3));
      end
      tick;
      g++;
      if (r) got++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (got !== 4 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end: words=%0d ov=%b want 4 0", got, out_valid);
    end
  endtask

  task automatic test_key_busy;
    logic [127:0] pt;
    logic en_pre;
    int n;
    pt = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    send_block(pt, 1'b1, en_pre);
    key_wr = 1'b1;
    key_idx = 4'd0;
    key_data = 32'hDEADBEEF;
    key_len_in = 4'd8;
    tick;
    key_wr = 1'b0;
    n_checks++;
    if (core_key[31:0] !== 32'd0 || core_key_len !== 4'd4 || key_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL key_in_run: key0=%h len=%0d busy=%b want 0 4 1",
               core_key[31:0], core_key_len, key_busy);
    end
    wait_out(n);
    key_wr = 1'b1;
    tick;
    key_wr = 1'b0;
    n_checks++;
    if (core_key[31:0] !== 32'hDEADBEEF || core_key_len !== 4'd8) begin
      n_fail++;
      $display("FAIL key_in_drain: key0=%h len=%0d want deadbeef 8",
               core_key[31:0], core_key_len);
    end
    drain(pt ^ 128'd1);
  endtask

  task automatic test_reset_mid_run;
    logic en_pre;
    send_block(128'h11111111_22222222_33333333_44444444, 1'b1, en_pre);
    tick;
    tick;
    n_checks++;
    if (core_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run: core_enable=%b want 1", core_enable);
    end
    RstN = 1'b0;
    #1;
    n_checks++;
    if (core_enable !== 1'b0 || key_busy !== 1'b0 || in_ready !== 1'b0 ||
        out_valid !== 1'b0 || core_pt !== 128'd0 || core_key !== 512'd0 ||
        core_key_len !== 4'd0 || core_encrypt !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: en=%b busy=%b rdy=%b ov=%b pt=%h len=%0d want all 0",
               core_enable, key_busy, in_ready, out_valid, core_pt, core_key_len);
    end
    tick;
    RstN = 1'b1;
    tick;
    n_checks++;
    if (in_ready !== 1'b1 || core_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_recover: rdy=%b en=%b want 1 0", in_ready, core_enable);
    end
  endtask

  task automatic test_timeout;
    logic [127:0] pt;
    logic en_pre;
    int n;
    hang2 = 1'b1;
    mon2 = 1'b1;
    send_block(128'hCAFEBABE_00000001_00000002_00000003, 1'b1, en_pre);
    n_checks++;
    if (core_enable_2 !== 1'b1 || err_timeout_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL to_start: en=%b err=%b want 1 0", core_enable_2, err_timeout_2);
    end
    n = 0;
    while (!err_timeout_2 && n < 100) begin
      tick;
      n++;
    end
    n_checks++;
    if (n !== 16 || err_timeout_2 !== 1'b1) begin
      n_fail++;
      $display("FAIL to_cycles: cycles=%0d err=%b want 16 1", n, err_timeout_2);
    end
    n_checks++;
    if (core_enable_2 !== 1'b0 || in_ready_2 !== 1'b1) begin
      n_fail++;
      $display("FAIL to_state: en=%b rdy=%b want 0 1", core_enable_2, in_ready_2);
    end
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick;
      n++;
    end
    out_ready = 1'b0;
    mon2 = 1'b0;
    n_checks++;
    if (seen_ov2 !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL to_no_output: seen_ov=%b rdy=%b want 0 1", seen_ov2, in_ready);
    end
    hang2 = 1'b0;
    pt = 128'h13579BDF_2468ACE0_DEADBEEF_0BADF00D;
    send_block(pt, 1'b1, en_pre);
    n_checks++;
    if (core_pt_2 !== pt || core_enable_2 !== 1'b1) begin
      n_fail++;
      $display("FAIL to_next_block: pt=%h en=%b want %h 1", core_pt_2, core_enable_2, pt);
    end
    n = 0;
    while (!out_valid_2 && n < 100) begin
      tick;
      n++;
    end
    n_checks++;
    if (n !== 6) begin
      n_fail++;
      $display("FAIL to_next_latency: cycles=%0d want 6", n);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid_2 !== 1'b1 || out_data_2 !== (pt[127 - 32*i -: 32] ^ ((i == 3) ? 32'd1 : 32'd0)) ||
          out_last_2 !== (i == 3)) begin
        n_fail++;
        $display("FAIL to_word %0d: v=%b d=%h l=%b", i, out_valid_2, out_data_2, out_last_2);
      end
      tick;
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid_2 !== 1'b0 || err_timeout_2 !== 1'b1) begin
      n_fail++;
      $display("FAIL to_sticky: ov=%b err=%b want 0 1", out_valid_2, err_timeout_2);
    end
  endtask

  initial begin
    test_reset;
    test_keys;
    test_block;
    test_stall;
    test_key_busy;
    test_reset_mid_run;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

endmodule
